ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Grants at most one access per cycle and routes read data back to the originating port one cycle later.
- Supports a short exclusive lock on port 1 so read-modify-write sequences are atomic.
- Sits between the core's fetch/data interfaces and the shared memory; the core stalls on ready=0.

Parameters:
- ADDR_W, 12, RAM word-address width
- DATA_W, 32, data width
- LOCK_MAX, 4, max consecutive cycles port 1 may hold the lock before it is forcibly released (1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- p0_valid  in  1  port 0 request valid
- p0_ready  out  1  port 0 request accepted this cycle
- p0_addr  in  ADDR_W  port 0 address
- p0_rvalid  out  1  port 0 read data valid
- p0_rdata  out  DATA_W  port 0 read data
- p1_valid  in  1  port 1 request valid
- p1_ready  out  1  port 1 request accepted this cycle
- p1_addr  in  ADDR_W  port 1 address
- p1_we  in  1  port 1 write enable (1 = store)
- p1_wdata  in  DATA_W  port 1 store data
- p1_lock  in  1  keep grant on port 1 after this access
- p1_rvalid  out  1  port 1 read data valid
- p1_rdata  out  DATA_W  port 1 read data
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wd  out  DATA_W  RAM write data
- ram_rd  in  DATA_W  RAM read data, valid the cycle after the address is presented

Behaviour:
- Handshake: a transfer occurs when valid & ready in the same cycle. Requesters hold valid/addr/data stable until ready. Ready is combinational from valid and arbiter state, and at most one ready is high per cycle.
- Port 0 is read-only. Port 1 reads when p1_we=0 and writes when p1_we=1.
- RAM drive:
  - When a grant is given, the granted port's addr is driven on ram_addr.
  - ram_we = p1_we & p1_valid & p1_ready.
  - ram_wd = p1_wdata.
  - With no grant, ram_we=0 and ram_addr holds its last value (don't-care).
- Read return: the cycle after an accepted read, pN_rvalid=1 for exactly one cycle and pN_rdata=ram_rd. Writes produce no rvalid. Back-to-back reads are allowed (throughput 1/cycle).
- Arbitration:
  - Round-robin on a last_grant register.
  - Only one port valid: that port is granted.
  - Both ports valid: the port not in last_grant is granted.
  - last_grant updates on every accepted transfer.
- Lock FSM, states OPEN and LOCKED:
  - OPEN -> LOCKED: on an accepted port 1 transfer with p1_lock=1; lock_cnt loads 0.
  - In LOCKED, p0_ready=0 and port 1 is granted whenever p1_valid=1. lock_cnt increments every cycle.
  - LOCKED -> OPEN: on an accepted port 1 transfer with p1_lock=0, or when lock_cnt reaches LOCK_MAX-1 (forced release at the end of that cycle).
  - On a forced release, last_grant is set to port 1 so a pending port 0 request wins next.
- Reset (rst=1 at a clock edge):
  - All outputs go low: ready, rvalid, ram_we, rdata=0.
  - State=OPEN, last_grant=port 1 (so port 0 wins the first tie), lock_cnt=0.
  - While rst is high, both ready outputs are held at 0.
  - A read accepted in the cycle before reset does not produce rvalid after reset.
- Simultaneous events:
  - A forced release and p1_lock=1 on the same cycle: the release wins.
  - A p1 write and a p0 read never share a cycle.

Optional Feature:
- RAM_ARB_FIXED_PRIO_EN defined: round-robin is replaced by fixed priority, port 1 (data) wins every tie. last_grant still tracks for the lock release rule, but it does not affect ties.
- Not defined: round-robin as specified above.

Test Plan:
- Reset, then p0 read addr 0x010 only, with RAM word 0x010 = 0x00000013 -> p0_ready=1 in cycle 1, p0_rvalid=1 with p0_rdata=0x00000013 in cycle 2; p1 outputs stay 0.
- Both valid for 4 cycles (p0 addr 0x000.., p1 read 0x100) -> grants alternate p0, p1, p0, p1; rvalid is returned to the matching port one cycle after each grant.
- p1 write 0xDEADBEEF to 0x020, then p0 read 0x020 -> ram_we=1 only in the write cycle; the next p0 read returns 0xDEADBEEF.
- p1_lock=1 read 0x030, then p1 write 0x030 with lock=0, while p0 is valid throughout -> p0_ready=0 for both cycles, and p0 is granted on the third cycle.
- p1 holds lock with continuous valid, LOCK_MAX=4 -> forced release after 4 locked cycles; the pending p0 request is granted next.
- Assert rst for 1 cycle immediately after an accepted p0 read -> no p0_rvalid afterwards, all outputs 0, first tie after reset goes to p0 (with the macro defined, to p1).

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters (fetch/data), the shared RAM and ram_arbiter.
// slave: arbiter side. master: requester and RAM side.
interface ram_arbiter_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   // Port 0: instruction fetch, read-only
   logic              p0_valid;
   logic              p0_ready;
   logic [ADDR_W-1:0] p0_addr;
   logic              p0_rvalid;
   logic [DATA_W-1:0] p0_rdata;

   // Port 1: data load/store with lock
   logic              p1_valid;
   logic              p1_ready;
   logic [ADDR_W-1:0] p1_addr;
   logic              p1_we;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_lock;
   logic              p1_rvalid;
   logic [DATA_W-1:0] p1_rdata;

   // Shared single-port synchronous RAM
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wd;
   logic [DATA_W-1:0] ram_rd;

   modport slave (
      input  p0_valid, p0_addr,
      input  p1_valid, p1_addr, p1_we, p1_wdata, p1_lock,
      input  ram_rd,
      output p0_ready, p0_rvalid, p0_rdata,
      output p1_ready, p1_rvalid, p1_rdata,
      output ram_addr, ram_we, ram_wd
   );

   modport master (
      output p0_valid, p0_addr,
      output p1_valid, p1_addr, p1_we, p1_wdata, p1_lock,
      output ram_rd,
      input  p0_ready, p0_rvalid, p0_rdata,
      input  p1_ready, p1_rvalid, p1_rdata,
      input  ram_addr, ram_we, ram_wd
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for one single-port synchronous RAM.
// Port 0 = fetch (read-only), port 1 = data (read/write, with a bounded exclusive lock).
// Optional build macro RAM_ARB_FIXED_PRIO_EN: ties go to port 1 instead of round-robin.
module ram_arbiter #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned LOCK_MAX = 4
) (
   input logic          clk,
   input logic          rst,
   ram_arbiter_if.slave bus
);

   localparam logic StOpen   = 1'b0;
   localparam logic StLocked = 1'b1;

   localparam logic [3:0] LockLast = 4'(LOCK_MAX - 1);

   logic              state_q, state_d;
   logic              last_grant_q, last_grant_d;  // 0 = port 0, 1 = port 1
   logic [3:0]        lock_cnt_q, lock_cnt_d;
   logic              p0_rvalid_q, p1_rvalid_q;
   logic [ADDR_W-1:0] addr_q;
   logic              gnt0, gnt1;

   // Grant decision: lock overrides, then single requester, then tie-break
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (state_q == StLocked) begin
            gnt1 = bus.p1_valid;
         end else if (bus.p0_valid && bus.p1_valid) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            gnt1 = 1'b1;
`else
            // Port not granted last time wins the tie
            if (last_grant_q) gnt0 = 1'b1;
            else              gnt1 = 1'b1;
`endif
         end else begin
            gnt0 = bus.p0_valid;
            gnt1 = bus.p1_valid;
         end
      end
   end

   // Handshake, RAM drive and read-return outputs
   always_comb begin
      bus.p0_ready  = gnt0;
      bus.p1_ready  = gnt1;
      bus.ram_we    = gnt1 & bus.p1_we;
      bus.ram_wd    = bus.p1_wdata;
      bus.ram_addr  = addr_q;
      if (gnt0)      bus.ram_addr = bus.p0_addr;
      else if (gnt1) bus.ram_addr = bus.p1_addr;
      // Outputs are forced low while reset is applied
      bus.p0_rvalid = p0_rvalid_q & ~rst;
      bus.p1_rvalid = p1_rvalid_q & ~rst;
      bus.p0_rdata  = bus.p0_rvalid ? bus.ram_rd : '0;
      bus.p1_rdata  = bus.p1_rvalid ? bus.ram_rd : '0;
   end

   // Lock FSM and round-robin history next state
   always_comb begin
      state_d      = state_q;
      lock_cnt_d   = lock_cnt_q;
      last_grant_d = last_grant_q;
      if (gnt0) last_grant_d = 1'b0;
      if (gnt1) last_grant_d = 1'b1;
      case (state_q)
         StOpen: begin
            if (gnt1 && bus.p1_lock) begin
               state_d    = StLocked;
               lock_cnt_d = 4'd0;
            end
         end
         StLocked: begin
            lock_cnt_d = lock_cnt_q + 4'd1;
            if (lock_cnt_q == LockLast) begin
               // Forced release beats any lock request this cycle; hand the next tie to port 0
               state_d      = StOpen;
               lock_cnt_d   = 4'd0;
               last_grant_d = 1'b1;
            end else if (gnt1 && !bus.p1_lock) begin
               state_d    = StOpen;
               lock_cnt_d = 4'd0;
            end
         end
         default: begin
            state_d    = StOpen;
            lock_cnt_d = 4'd0;
         end
      endcase
   end

   // State, read-return tracking and held RAM address
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StOpen;
         last_grant_q <= 1'b1;
         lock_cnt_q   <= 4'd0;
         p0_rvalid_q  <= 1'b0;
         p1_rvalid_q  <= 1'b0;
         addr_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lock_cnt_q   <= lock_cnt_d;
         p0_rvalid_q  <= gnt0;
         p1_rvalid_q  <= gnt1 & ~bus.p1_we;
         addr_q       <= bus.ram_addr;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, hand-written lock/reset
// sequences, then randomized requesters against a transaction-level reference model.
module tb_ram_arbiter;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;
   localparam int unsigned LM = 4;
`ifdef RAM_ARB_FIXED_PRIO_EN
   localparam bit Fixed = 1'b1;
`else
   localparam bit Fixed = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic mem_init;
   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [31:0] init_val(input logic [11:0] a);
      if (a == 12'h010) return 32'h0000_0013;
      return 32'hC0DE_0000 | {20'd0, a};
   endfunction

   // Synchronous single-port RAM
   logic [DW-1:0] mem [4096];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_val(12'(i));
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_wd;
      end
      bus.ram_rd <= mem[bus.ram_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit p0v, input logic [11:0] p0a, input bit p1v,
                        input logic [11:0] p1a, input bit we, input logic [31:0] wd,
                        input bit lk);
      bus.p0_valid = p0v;
      bus.p0_addr  = p0a;
      bus.p1_valid = p1v;
      bus.p1_addr  = p1a;
      bus.p1_we    = we;
      bus.p1_wdata = wd;
      bus.p1_lock  = lk;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          p0v;
      logic [11:0] p0a;
      bit          p1v;
      logic [11:0] p1a;
      bit          we;
      logic [31:0] wd;
      bit          lk;
      bit          e0r;
      bit          e1r;
      bit          ewe;
      bit          e0v;
      logic [31:0] e0d;
      bit          e1v;
      logic [31:0] e1d;
   } vec_t;

   function automatic vec_t mk(input bit p0v, input logic [11:0] p0a, input bit p1v,
                               input logic [11:0] p1a, input bit we, input logic [31:0] wd,
                               input bit lk, input bit e0r, input bit e1r, input bit ewe,
                               input bit e0v, input logic [31:0] e0d, input bit e1v,
                               input logic [31:0] e1d);
      vec_t v;
      v.p0v = p0v; v.p0a = p0a; v.p1v = p1v; v.p1a = p1a; v.we = we; v.wd = wd; v.lk = lk;
      v.e0r = e0r; v.e1r = e1r; v.ewe = ewe;
      v.e0v = e0v; v.e0d = e0d; v.e1v = e1v; v.e1d = e1d;
      return v;
   endfunction

   vec_t tbl [13];

   // Reference model state for the random phase
   logic [31:0] shadow [4096];
   int          lastg, lcyc, pend_port, g;
   bit          locked;
   logic [31:0] pend_data;
   bit          h0, h1, we1, lk1;
   logic [11:0] a0, a1;
   logic [31:0] wd1;

   initial begin
      for (int i = 0; i < 4096; i++) shadow[i] = init_val(12'(i));

      // ---------------- reset ----------------
      rst = 1'b1;
      mem_init = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      mem_init = 1'b0;
      drive(1, 12'h000, 1, 12'h100, 0, 0, 0);
      @(negedge clk);
      check("rst_p0_ready", bus.p0_ready, 0);
      check("rst_p1_ready", bus.p1_ready, 0);
      next_cycle();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("post_rst_p0_rvalid", bus.p0_rvalid, 0);
      check("post_rst_p1_rvalid", bus.p1_rvalid, 0);
      check("post_rst_ram_we", bus.ram_we, 0);
      check("post_rst_p0_rdata", bus.p0_rdata, 0);
      check("post_rst_p1_rdata", bus.p1_rdata, 0);
      next_cycle();

      // ---------------- vector table ----------------
      tbl[0]  = mk(1, 12'h010, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 1, 12'h020, 1, 32'hDEADBEEF, 0,  0, 1, 1,  1, 32'h13, 0, 0);
      tbl[2]  = mk(1, 12'h020, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 12'h100, 0, 0, 0,  0, 1, 0,  1, 32'hDEADBEEF, 0, 0);
      tbl[4]  = mk(1, 12'h000, 1, 12'h100, 0, 0, 0,  !Fixed, Fixed, 0,
                   0, 0, 1, init_val(12'h100));
      tbl[5]  = mk(1, 12'h000, 1, 12'h100, 0, 0, 0,  0, 1, 0,
                   !Fixed, init_val(12'h000), Fixed, init_val(12'h100));
      tbl[6]  = mk(1, 12'h000, 1, 12'h100, 0, 0, 0,  !Fixed, Fixed, 0,
                   0, 0, 1, init_val(12'h100));
      tbl[7]  = mk(1, 12'h000, 1, 12'h100, 0, 0, 0,  0, 1, 0,
                   !Fixed, init_val(12'h000), Fixed, init_val(12'h100));
      tbl[8]  = mk(1, 12'h000, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 1, init_val(12'h100));
      tbl[9]  = mk(1, 12'h000, 1, 12'h030, 0, 0, 1,  0, 1, 0,  1, init_val(12'h000), 0, 0);
      tbl[10] = mk(1, 12'h000, 1, 12'h030, 1, 32'h12345678, 0,  0, 1, 1,
                   0, 0, 1, init_val(12'h030));
      tbl[11] = mk(1, 12'h000, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, init_val(12'h000), 0, 0);

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].p0v, tbl[i].p0a, tbl[i].p1v, tbl[i].p1a, tbl[i].we, tbl[i].wd, tbl[i].lk);
         @(negedge clk);
         check($sformatf("vec%0d_p0_ready", i), bus.p0_ready, tbl[i].e0r);
         check($sformatf("vec%0d_p1_ready", i), bus.p1_ready, tbl[i].e1r);
         check($sformatf("vec%0d_ram_we", i), bus.ram_we, tbl[i].ewe);
         check($sformatf("vec%0d_p0_rvalid", i), bus.p0_rvalid, tbl[i].e0v);
         check($sformatf("vec%0d_p1_rvalid", i), bus.p1_rvalid, tbl[i].e1v);
         if (tbl[i].e0v) check($sformatf("vec%0d_p0_rdata", i), bus.p0_rdata, tbl[i].e0d);
         if (tbl[i].e1v) check($sformatf("vec%0d_p1_rdata", i), bus.p1_rdata, tbl[i].e1d);
         if (tbl[i].e0r) check($sformatf("vec%0d_ram_addr", i), bus.ram_addr, tbl[i].p0a);
         if (tbl[i].e1r) check($sformatf("vec%0d_ram_addr", i), bus.ram_addr, tbl[i].p1a);
         next_cycle();
      end

      // ---------------- forced lock release ----------------
      drive(0, 0, 1, 12'h040, 0, 0, 1);
      @(negedge clk);
      check("lock_enter_p1_ready", bus.p1_ready, 1);
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         drive(1, 12'h000, 1, 12'h041 + 12'(k), 0, 0, 1);
         @(negedge clk);
         check($sformatf("locked%0d_p0_ready", k), bus.p0_ready, 0);
         check($sformatf("locked%0d_p1_ready", k), bus.p1_ready, 1);
         next_cycle();
      end
      drive(1, 12'h000, 1, 12'h050, 0, 0, 0);
      @(negedge clk);
      check("release_p0_ready", bus.p0_ready, !Fixed);
      check("release_p1_ready", bus.p1_ready, Fixed);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0);
      next_cycle();

      // ---------------- reset right after an accepted read ----------------
      drive(1, 12'h060, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("prerst_p0_ready", bus.p0_ready, 1);
      next_cycle();
      rst = 1'b1;
      drive(1, 12'h000, 1, 12'h100, 0, 0, 0);
      @(negedge clk);
      check("inrst_p0_ready", bus.p0_ready, 0);
      check("inrst_p1_ready", bus.p1_ready, 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("afterrst_p0_rvalid", bus.p0_rvalid, 0);
      check("afterrst_p1_rvalid", bus.p1_rvalid, 0);
      check("afterrst_p0_rdata", bus.p0_rdata, 0);
      check("afterrst_ram_we", bus.ram_we, 0);
      check("afterrst_tie_p0_ready", bus.p0_ready, !Fixed);
      check("afterrst_tie_p1_ready", bus.p1_ready, Fixed);
      next_cycle();

      // ---------------- randomized phase vs reference model ----------------
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      rst = 1'b0;
      lastg = 1; locked = 0; lcyc = 0; pend_port = -1; pend_data = '0;
      h0 = 0; h1 = 0; a0 = '0; a1 = '0; we1 = 0; wd1 = '0; lk1 = 0;
      for (int c = 0; c < 1500; c++) begin
         // Requesters keep a request stable until it is accepted
         if (!h0) begin
            h0 = ($urandom_range(0, 2) != 0);
            a0 = 12'h200 + 12'($urandom_range(0, 31));
         end
         if (!h1) begin
            h1  = ($urandom_range(0, 2) != 0);
            a1  = 12'h200 + 12'($urandom_range(0, 31));
            we1 = ($urandom_range(0, 1) != 0);
            wd1 = $urandom;
            lk1 = ($urandom_range(0, 2) == 0);
         end
         drive(h0, a0, h1, a1, we1, wd1, lk1);

         g = -1;
         if (locked) begin
            if (h1) g = 1;
         end else if (h0 && h1) begin
            g = Fixed ? 1 : (lastg == 1 ? 0 : 1);
         end else if (h0) begin
            g = 0;
         end else if (h1) begin
            g = 1;
         end

         @(negedge clk);
         check("rnd_p0_ready", bus.p0_ready, (g == 0));
         check("rnd_p1_ready", bus.p1_ready, (g == 1));
         check("rnd_ram_we", bus.ram_we, (g == 1) && we1);
         if (g == 0) check("rnd_ram_addr0", bus.ram_addr, a0);
         if (g == 1) check("rnd_ram_addr1", bus.ram_addr, a1);
         check("rnd_p0_rvalid", bus.p0_rvalid, (pend_port == 0));
         check("rnd_p1_rvalid", bus.p1_rvalid, (pend_port == 1));
         if (pend_port == 0) check("rnd_p0_rdata", bus.p0_rdata, pend_data);
         if (pend_port == 1) check("rnd_p1_rdata", bus.p1_rdata, pend_data);

         pend_port = -1;
         if (g == 0) begin
            pend_port = 0;
            pend_data = shadow[a0];
            h0 = 0;
         end
         if (g == 1) begin
            if (we1) shadow[a1] = wd1;
            else begin
               pend_port = 1;
               pend_data = shadow[a1];
            end
            h1 = 0;
         end
         if (g >= 0) lastg = g;
         // Lock lasts at most LM cycles after the locking transfer
         if (locked) begin
            lcyc++;
            if (lcyc == LM) begin
               locked = 0;
               lastg  = 1;
            end else if (g == 1 && !lk1) begin
               locked = 0;
            end
         end else if (g == 1 && lk1) begin
            locked = 1;
            lcyc   = 0;
         end
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
